// File: rtl/gc_updt_tx_if.sv
// Request and TRN transmit signals of the GC-update TLP generator.
interface gc_updt_tx_if;
    logic [63:0] gc_addr;
    logic        gc_updt;
    logic        gc_updt_ack;
    logic [63:0] host_gc_addr;
    logic [15:0] cfg_completer_id;
    logic        trn_lnk_up_n;
    logic [3:0]  trn_tbuf_av;
    logic        my_turn;
    logic        driving_interface;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;

    modport master (
        output gc_addr, gc_updt, host_gc_addr, cfg_completer_id, trn_lnk_up_n,
               trn_tbuf_av, my_turn, trn_tdst_rdy_n,
        input  gc_updt_ack, driving_interface, trn_td, trn_trem_n, trn_tsof_n,
               trn_teof_n, trn_tsrc_rdy_n
    );

    modport slave (
        input  gc_addr, gc_updt, host_gc_addr, cfg_completer_id, trn_lnk_up_n,
               trn_tbuf_av, my_turn, trn_tdst_rdy_n,
        output gc_updt_ack, driving_interface, trn_td, trn_trem_n, trn_tsof_n,
               trn_teof_n, trn_tsrc_rdy_n
    );
endinterface

// File: rtl/gc_updt_tx.sv
// Publishes gc_addr to a host status QW as one posted MWr TLP per gc_updt request.
// Optional macro GC_UPDT_3DW_EN: use a 3DW header when the host address is below 4 GiB.
module gc_updt_tx (
    input  logic         clk,
    input  logic         rst,
    gc_updt_tx_if.slave  bus
);
    localparam int unsigned DATA_W = 64;
    localparam logic [31:0] DW0_4DW = 32'h6000_0002;

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, ACK, DROP} state_t;

    state_t              state;
    logic [DATA_W-1:0]   gc_q;
    logic [63:3]         ha_q;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    wire start_c    = bus.gc_updt && bus.my_turn && bus.trn_tbuf_av[1] && !bus.trn_lnk_up_n;
    wire in_frame_c = (state == HDR0) || (state == HDR1) || (state == DATA);
    wire accept_c   = !bus.trn_tsrc_rdy_n && !bus.trn_tdst_rdy_n;
    wire [31:0] hdr_dw1_c = {bus.cfg_completer_id, 8'h00, 4'hF, 4'hF};

    // Only posted credit and the QW-aligned part of the host address matter.
    wire unused_ok = ^{bus.trn_tbuf_av[3:2], bus.trn_tbuf_av[0], bus.host_gc_addr[2:0]};

`ifdef GC_UPDT_3DW_EN
    localparam logic [31:0] DW0_3DW = 32'h4000_0002;
    logic fmt3_q;
    wire  fmt3_start_c = (bus.host_gc_addr[63:32] == 32'h0);

    always_ff @(posedge clk) begin
        if (rst)
            fmt3_q <= 1'b0;
        else if (state == IDLE && start_c)
            fmt3_q <= fmt3_start_c;
    end

    wire [63:0] beat0_c = {(fmt3_start_c ? DW0_3DW : DW0_4DW), hdr_dw1_c};
    wire [63:0] beat1_c = fmt3_q ? {ha_q[31:3], 3'b000, bswap32(gc_q[31:0])}
                                 : {ha_q[63:32], ha_q[31:3], 3'b000};
    wire [63:0] beat2_c = fmt3_q ? {bswap32(gc_q[63:32]), 32'h0}
                                 : {bswap32(gc_q[31:0]), bswap32(gc_q[63:32])};
    wire [7:0]  trem2_c = fmt3_q ? 8'h0F : 8'h00;
`else
    wire [63:0] beat0_c = {DW0_4DW, hdr_dw1_c};
    wire [63:0] beat1_c = {ha_q[63:32], ha_q[31:3], 3'b000};
    wire [63:0] beat2_c = {bswap32(gc_q[31:0]), bswap32(gc_q[63:32])};
    wire [7:0]  trem2_c = 8'h00;
`endif

    // Frame sequencer; every TRN output is a register that holds until its beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            gc_q                  <= '0;
            ha_q                  <= '0;
            bus.gc_updt_ack       <= 1'b0;
            bus.driving_interface <= 1'b0;
            bus.trn_tsrc_rdy_n    <= 1'b1;
            bus.trn_tsof_n        <= 1'b1;
            bus.trn_teof_n        <= 1'b1;
            bus.trn_trem_n        <= 8'h00;
            bus.trn_td            <= '0;
        end else if (in_frame_c && bus.trn_lnk_up_n) begin
            // Link loss abandons the frame without ack; the held request retries later.
            state                 <= IDLE;
            bus.driving_interface <= 1'b0;
            bus.trn_tsrc_rdy_n    <= 1'b1;
            bus.trn_tsof_n        <= 1'b1;
            bus.trn_teof_n        <= 1'b1;
            bus.trn_trem_n        <= 8'h00;
            bus.trn_td            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_c) begin
                        gc_q                  <= bus.gc_addr;
                        ha_q                  <= bus.host_gc_addr[63:3];
                        bus.driving_interface <= 1'b1;
                        bus.trn_td            <= beat0_c;
                        bus.trn_tsof_n        <= 1'b0;
                        bus.trn_teof_n        <= 1'b1;
                        bus.trn_trem_n        <= 8'h00;
                        bus.trn_tsrc_rdy_n    <= 1'b0;
                        state                 <= HDR0;
                    end
                end
                HDR0: begin
                    if (accept_c) begin
                        bus.trn_td     <= beat1_c;
                        bus.trn_tsof_n <= 1'b1;
                        state          <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept_c) begin
                        bus.trn_td     <= beat2_c;
                        bus.trn_teof_n <= 1'b0;
                        bus.trn_trem_n <= trem2_c;
                        state          <= DATA;
                    end
                end
                DATA: begin
                    if (accept_c) begin
                        bus.trn_td            <= '0;
                        bus.trn_teof_n        <= 1'b1;
                        bus.trn_trem_n        <= 8'h00;
                        bus.trn_tsrc_rdy_n    <= 1'b1;
                        bus.driving_interface <= 1'b0;
                        bus.gc_updt_ack       <= 1'b1;
                        state                 <= ACK;
                    end
                end
                ACK: begin
                    bus.gc_updt_ack <= 1'b0;
                    state           <= DROP;
                end
                DROP: begin
                    if (!bus.gc_updt)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gc_updt_tx.sv
// Scoreboard bench for gc_updt_tx: a DW-level TLP model feeds a beat queue checked by a monitor.
`timescale 1ns/1ps
module tb_gc_updt_tx;
    typedef struct packed {
        logic [63:0] td;
        logic        sof_n;
        logic        eof_n;
        logic [7:0]  trem_n;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    gc_updt_tx_if bus();

    gc_updt_tx dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_cmp = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    int    frames_pushed = 0;
    int    frames_done = 0;
    int    ack_cnt = 0;
    int    ack_cyc = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
        return r;
    endfunction

    // DW0: R, fmt, type(MWr=0), R, TC, R, TD, EP, attr, AT, length.
    function automatic logic [31:0] mk_dw0(input logic [1:0] fmt, input logic [9:0] len);
        return {1'b0, fmt, 5'b00000, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len};
    endfunction

    // Build the TLP as a DW list, then pack it two DWs per beat.
    task automatic push_frame(input logic [63:0] gc, input logic [63:0] ha, input logic [15:0] cid);
        logic [31:0] dws[$];
        logic [63:0] ha_al;
        bit          three;
        ha_al = {ha[63:3], 3'b000};
        three = 1'b0;
`ifdef GC_UPDT_3DW_EN
        three = (ha[63:32] == 32'h0);
`endif
        dws.push_back(mk_dw0(three ? 2'b10 : 2'b11, 10'd2));
        dws.push_back({cid, 8'h00, 4'hF, 4'hF});
        if (!three) dws.push_back(ha_al[63:32]);
        dws.push_back(ha_al[31:0]);
        dws.push_back(bswap(gc[31:0]));
        dws.push_back(bswap(gc[63:32]));
        for (int i = 0; i < dws.size(); i += 2) begin
            beat_t b;
            b.sof_n = (i != 0);
            b.eof_n = (i + 2 < dws.size());
            if (i + 1 < dws.size()) begin
                b.td     = {dws[i], dws[i+1]};
                b.trem_n = 8'h00;
            end else begin
                b.td     = {dws[i], 32'h0};
                b.trem_n = 8'h0F;
            end
            exp_q.push_back(b);
        end
        frames_pushed++;
    endtask

    // Monitor: collects accepted beats per frame, checks hold-on-stall and ack behaviour.
    beat_t buf_q[$];
    beat_t prev;
    bit    prev_stall = 1'b0;
    bit    prev_ack = 1'b0;
    always @(negedge clk) begin : mon
        beat_t cur;
        cur.td     = bus.trn_td;
        cur.sof_n  = bus.trn_tsof_n;
        cur.eof_n  = bus.trn_teof_n;
        cur.trem_n = bus.trn_trem_n;
        if (rst || bus.trn_lnk_up_n) begin
            buf_q.delete();
            prev_stall = 1'b0;
            prev_ack   = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_on_stall", 128'({cur, bus.trn_tsrc_rdy_n, bus.driving_interface}),
                    128'({prev, 1'b0, 1'b1}));
            if (!bus.trn_tsrc_rdy_n && !bus.trn_tdst_rdy_n) begin
                if (!cur.sof_n) buf_q.delete();
                buf_q.push_back(cur);
                if (!cur.eof_n) begin
                    foreach (buf_q[i]) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL unexpected_beat: got %h expected none", buf_q[i]);
                        end else begin
                            chk("beat", 128'(buf_q[i]), 128'(exp_q.pop_front()));
                        end
                    end
                    buf_q.delete();
                    frames_done++;
                end
            end
            if (prev_ack) chk("ack_pulse_width", 128'(bus.gc_updt_ack), 128'(0));
            if (bus.gc_updt_ack) begin
                chk("ack_after_frame", 128'(ack_cnt + 1), 128'(frames_done));
                chk("ack_driving_low", 128'(bus.driving_interface), 128'(0));
                ack_cnt++;
                ack_cyc = cyc;
            end
            prev_stall = !bus.trn_tsrc_rdy_n && bus.trn_tdst_rdy_n;
            prev       = cur;
            prev_ack   = bus.gc_updt_ack;
        end
    end

    // One request: my_turn withheld for d cycles, tdst_rdy_n stalled on [st_lo,st_hi] or randomly.
    task automatic run_req(input logic [63:0] gc, input logic [63:0] ha, input logic [15:0] cid,
                           input int d, input int st_lo, input int st_hi, input bit rnd,
                           input int hold, input bit drop_turn);
        int k;
        int stalls;
        int a0;
        int req_cyc;
        bit quiet_ok;
        bus.gc_addr          = gc;
        bus.host_gc_addr     = ha;
        bus.cfg_completer_id = cid;
        bus.gc_updt          = 1'b1;
        req_cyc  = cyc;
        a0       = ack_cnt;
        k        = 0;
        stalls   = 0;
        quiet_ok = 1'b1;
        push_frame(gc, ha, cid);
        while (ack_cnt == a0 && k < 300) begin
            if (k == 0) bus.my_turn = (d == 0);
            if (k == d) bus.my_turn = 1'b1;
            if (drop_turn && k == d + 2) bus.my_turn = 1'b0;
            bus.trn_tdst_rdy_n = rnd ? ($urandom_range(0, 3) == 0) : (k >= st_lo && k <= st_hi);
            if (!bus.trn_tsrc_rdy_n && bus.trn_tdst_rdy_n) stalls++;
            if (k <= d && (bus.driving_interface || !bus.trn_tsof_n)) quiet_ok = 1'b0;
            step();
            k++;
        end
        bus.trn_tdst_rdy_n = 1'b0;
        if (ack_cnt == a0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack after %0d cycles required one", k);
        end else begin
            chk("ack_latency", 128'(ack_cyc), 128'(req_cyc + d + 4 + stalls));
        end
        if (d > 0) chk("quiet_without_turn", 128'(quiet_ok), 128'(1));
        repeat (hold) step();
        bus.gc_updt = 1'b0;
        step();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin : main
        int a0;
        int k;
        bus.gc_addr          = '0;
        bus.host_gc_addr     = '0;
        bus.cfg_completer_id = '0;
        bus.gc_updt          = 1'b0;
        bus.trn_lnk_up_n     = 1'b0;
        bus.trn_tbuf_av      = 4'hF;
        bus.my_turn          = 1'b0;
        bus.trn_tdst_rdy_n   = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        chk("reset_outputs",
            128'({bus.gc_updt_ack, bus.driving_interface, bus.trn_tsrc_rdy_n, bus.trn_tsof_n,
                  bus.trn_teof_n, bus.trn_trem_n, bus.trn_td}),
            128'({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 64'h0}));
        rst = 1'b0;
        step();

        // Basic, backpressure in HDR1, arbitration with mid-frame turn loss, held request.
        run_req(64'h0000_0001_2345_6780, 64'h0000_0002_0000_1008, 16'h0100, 0, -1, -1, 1'b0, 0, 1'b0);
        run_req(64'h0000_0001_2345_6780, 64'h0000_0002_0000_1008, 16'h0100, 0, 2, 4, 1'b0, 0, 1'b0);
        run_req(64'hDEAD_BEEF_0BAD_F00D, 64'h0000_0003_ABCD_EF17, 16'h1234, 10, -1, -1, 1'b0, 0, 1'b1);
        run_req(64'h1111_2222_3333_4444, 64'h0000_0004_0000_0000, 16'h00A5, 0, -1, -1, 1'b0, 5, 1'b0);
        run_req(64'h5555_6666_7777_8888, 64'h0000_0004_0000_0040, 16'h00A5, 0, -1, -1, 1'b0, 0, 1'b0);
        run_req(64'h0123_4567_89AB_CDEF, 64'h0000_0000_8000_0010, 16'h0100, 0, -1, -1, 1'b0, 0, 1'b0);

        // Reset while the data beat is presented.
        bus.gc_addr = 64'hCAFE_0000_0000_0001;
        bus.host_gc_addr = 64'h0000_0005_0000_0000;
        bus.gc_updt = 1'b1;
        bus.my_turn = 1'b1;
        a0 = ack_cnt;
        repeat (3) step();
        rst = 1'b1;
        bus.gc_updt = 1'b0;
        step();
        chk("rst_mid_frame",
            128'({bus.trn_tsrc_rdy_n, bus.driving_interface, bus.gc_updt_ack, bus.trn_teof_n}),
            128'({1'b1, 1'b0, 1'b0, 1'b1}));
        rst = 1'b0;
        repeat (3) step();
        chk("rst_no_ack", 128'(ack_cnt), 128'(a0));

        // Link drop during HDR1; request retried once the link returns.
        bus.gc_addr = 64'hFEED_FACE_1234_5678;
        bus.host_gc_addr = 64'h0000_0006_0000_0088;
        bus.cfg_completer_id = 16'h0203;
        bus.gc_updt = 1'b1;
        a0 = ack_cnt;
        push_frame(bus.gc_addr, bus.host_gc_addr, bus.cfg_completer_id);
        repeat (2) step();
        bus.trn_lnk_up_n = 1'b1;
        step();
        chk("link_abort", 128'({bus.trn_tsrc_rdy_n, bus.driving_interface, bus.gc_updt_ack}),
            128'({1'b1, 1'b0, 1'b0}));
        repeat (3) step();
        chk("link_down_idle", 128'({bus.driving_interface, ack_cnt}), 128'({1'b0, a0}));
        bus.trn_lnk_up_n = 1'b0;
        k = 0;
        while (ack_cnt == a0 && k < 100) begin
            step();
            k++;
        end
        chk("link_retry_ack", 128'(ack_cnt), 128'(a0 + 1));
        bus.gc_updt = 1'b0;
        repeat (2) step();

        // Randomized requests with random stalls, arbitration delay and hold.
        for (int it = 0; it < 30; it++) begin
            logic [63:0] gc;
            logic [63:0] ha;
            gc = {$urandom, $urandom};
            ha = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) ha[63:32] = 32'h0;
            bus.trn_tbuf_av = 4'($urandom) | 4'b0010;
            run_req(gc, ha, 16'($urandom), int'($urandom_range(0, 3)), -1, -1, 1'b1,
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (4) step();
        chk("frames_done", 128'(frames_done), 128'(frames_pushed));
        chk("ack_count", 128'(ack_cnt), 128'(frames_pushed));
        chk("exp_q_empty", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/gc_updt_tx.md
# gc_updt_tx

Downstream consumer of the garbage-collection update request from the pulled-data monitor. On each `gc_updt` request it captures the 64-bit `gc_addr`, wins the shared TRN transmit interface, and emits one posted Memory Write TLP carrying that value to a host-resident status location. It then returns a one-cycle `gc_updt_ack`. The block sits between the monitor and the PCIe endpoint transmit arbiter, in parallel with the other TLP generators.

## Interface
Parameters:
- None.

Ports:
- `clk` — in — 1 — core clock; all logic is in this domain.
- `rst` — in — 1 — synchronous, active-high reset.
- `gc_addr` — in — 64 — value to publish to the host; sampled at request acceptance.
- `gc_updt` — in — 1 — level request; held until acked.
- `gc_updt_ack` — out — 1 — one-cycle pulse after the TLP is fully accepted.
- `host_gc_addr` — in — 64 — host byte address of the status QW; bits [2:0] are ignored and treated as 0.
- `cfg_completer_id` — in — 16 — requester ID for the TLP header.
- `trn_lnk_up_n` — in — 1 — link down when high.
- `trn_tbuf_av` — in — 4 — endpoint buffer availability; bit 1 = posted credit.
- `my_turn` — in — 1 — grant from the TX arbiter.
- `driving_interface` — out — 1 — high while this block owns the TRN TX bus.
- `trn_td` — out — 64 — TLP data, DW0 in [63:32].
- `trn_trem_n` — out — 8 — 8'h00 = both DWs valid, 8'h0F = upper DW only.
- `trn_tsof_n` / `trn_teof_n` — out — 1 each — start / end of frame.
- `trn_tsrc_rdy_n` — out — 1 — source ready.
- `trn_tdst_rdy_n` — in — 1 — destination ready.

## Operation
- FSM states: IDLE, HDR0, HDR1, DATA, ACK, DROP.
- **IDLE**
  - Start condition: `gc_updt && my_turn && trn_tbuf_av[1] && !trn_lnk_up_n`.
  - On start: latch `gc_addr` into `gc_q` and `host_gc_addr` into `ha_q`, set `driving_interface`, go to HDR0.
- **HDR0**: present beat 0 with `tsof_n=0`, `src_rdy_n=0`.
  - DW0 = 32'h6000_0002: fmt 11, type MWr, TC/TD/EP/attr 0, length 2.
  - DW1 = {`cfg_completer_id`, tag 8'h00, lastBE 4'hF, firstBE 4'hF}.
- **HDR1**: beat 1 = {`ha_q[63:32]`, `ha_q[31:3]`, 3'b000}.
- **DATA**: beat 2 = {bswap32(`gc_q[31:0]`), bswap32(`gc_q[63:32]`)}, `teof_n=0`, `trem_n=8'h00`.
- Beat advance: a beat is accepted only on a cycle with `src_rdy_n=0` and `tdst_rdy_n=0`. While not accepted, every TRN output holds its value.
- **ACK**: `src_rdy_n=1`, `driving_interface=0`, `gc_updt_ack=1` for exactly one cycle, then go to DROP.
- **DROP**: wait for `gc_updt==0`, then go to IDLE. This prevents retriggering on a stale level.
- Once HDR0 is entered, changes on `my_turn`, `trn_tbuf_av` and `gc_updt` are ignored until ACK.
- Link down (`trn_lnk_up_n=1`) mid-frame: abort to IDLE, drop `driving_interface` and `src_rdy_n`, no ack. The request is re-sent after the link recovers.

## Timing
- Reset values: `gc_updt_ack=0`, `driving_interface=0`, `trn_tsrc_rdy_n=1`, `trn_tsof_n=1`, `trn_teof_n=1`, `trn_trem_n=8'h00`, `trn_td=0`, FSM=IDLE.
- Reset mid-frame: all of the above take effect the next cycle; the frame is abandoned.
- Start condition true at cycle T:
  - beat 0 is valid at T+1;
  - with `tdst_rdy_n` held low, beats 1 and 2 are valid at T+2 and T+3;
  - ack pulses at T+4; `driving_interface` is low from T+4.
- Minimum request-to-ack latency is 4 cycles; each `tdst_rdy_n` stall adds one cycle.
- A new request may start no earlier than 2 cycles after the ack pulse, since `gc_updt` must be seen low in DROP first.

## Configuration
- Macro: `GC_UPDT_3DW_EN`.
- **Defined**, and `ha_q[63:32]==0` at latch: send a 3DW-header TLP, 3 beats.
  - Beat 0 DW0 = 32'h4000_0002, DW1 unchanged.
  - Beat 1 = {`ha_q[31:3]`, 3'b000, bswap32(`gc_q[31:0]`)}.
  - Beat 2 = {bswap32(`gc_q[63:32]`), 32'h0}, `trem_n=8'h0F`.
  - Latency is the same. Addresses at or above 4 GiB still use the 4DW format.
- **Undefined**: the 4DW format is always used; the 3DW path is absent from the netlist.

## Test plan
- Basic, no stalls: `gc_addr=64'h0000_0001_2345_6780`, `host_gc_addr=64'h0000_0002_0000_1008`, `cfg_completer_id=16'h0100`, `my_turn`, `tdst_rdy_n`, `tbuf_av=4'hF`.
  - Beats: 64'h6000_0002_0100_00FF, 64'h0000_0002_0000_1008, 64'h8067_4523_0100_0000.
  - Ack exactly 4 cycles after request.
- Backpressure: `tdst_rdy_n` high for 3 cycles during HDR1 → beat 1 held stable throughout; ack at T+7; exactly one TLP.
- Arbitration: `gc_updt` high with `my_turn=0` for 10 cycles → `driving_interface` stays 0, no SOF. Raise `my_turn` → frame starts next cycle. Drop `my_turn` mid-frame → frame still completes.
- Held request: keep `gc_updt` high for 5 cycles after the ack → no second TLP; a second TLP starts only after `gc_updt` low then high again.
- Reset/link: assert `rst` in DATA → next cycle `src_rdy_n=1`, `driving_interface=0`, no ack. Assert `trn_lnk_up_n` in HDR1 → same, and the request is sent after the link comes back up.
- With `GC_UPDT_3DW_EN`: `host_gc_addr=64'h0000_0000_8000_0010` → beat 0 = 64'h4000_0002_0100_00FF, beat 2 `trem_n=8'h0F`.
